// File: rtl/regfile_dump_reader.sv
// Streams a contiguous register range out of the 32x32 register file over valid/ready.
// Drives the file's async read port from a registered pointer and registers each beat.
module regfile_dump_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_e;

    state_e r_state;
    state_e w_next_state;

    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_last_q;
    logic [DATA_W-1:0] r_out_data;
    logic [ADDR_W-1:0] r_out_addr;
    logic              r_out_last;
    logic              r_out_valid;
    logic              r_done;
    logic              r_err;

    logic w_fire;
    logic w_start_ok;
    logic w_start_bad;
    logic w_capture;
    logic w_finish;
    logic w_drop;

    assign w_fire = r_out_valid & out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of process ordering.
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start && (first_reg <= last_reg)) w_next_state = ST_LOAD;
            end
            ST_LOAD: begin
                w_next_state = abort ? ST_IDLE : ST_SEND;
            end
            ST_SEND: begin
                if (abort)                      w_next_state = ST_IDLE;
                else if (w_fire && r_out_last)  w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Output/datapath control decode; abort overrides any simultaneous fire
    always_comb begin
        w_start_ok  = 1'b0;
        w_start_bad = 1'b0;
        w_capture   = 1'b0;
        w_finish    = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_start_ok  = start && (first_reg <= last_reg);
                w_start_bad = start && (first_reg >  last_reg);
            end
            ST_LOAD: begin
                w_capture = !abort;
                w_drop    = abort;
            end
            ST_SEND: begin
                w_capture = !abort && w_fire && !r_out_last;
                w_finish  = !abort && w_fire &&  r_out_last;
                w_drop    = abort;
            end
            default: ;
        endcase
    end

    // Datapath: pointer, range bound and the registered output beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_last_q    <= '0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= w_finish;
            r_err  <= w_start_bad;
            if (w_start_ok) begin
                r_ptr    <= first_reg;
                r_last_q <= last_reg;
            end
            if (w_capture) begin
                // Register sampled on this edge; later writebacks are not seen
                r_out_data  <= rd_data;
                r_out_addr  <= r_ptr;
                r_out_last  <= (r_ptr == r_last_q);
                r_out_valid <= 1'b1;
                r_ptr       <= r_ptr + 1'b1;
            end else if (w_finish || w_drop) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign rd_addr   = r_ptr;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_addr  = r_out_addr;
    assign out_last  = r_out_last;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign err       = r_err;

`ifndef SYNTHESIS
    // A presented beat may only be withdrawn by a fire, abort or reset
    a_valid_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (r_out_valid && !out_ready && !abort) |=> r_out_valid);
`endif

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Streams a contiguous range of architectural registers out of the 32x32 register file over a valid/ready interface, for debug dump and state checkpointing.
- It is the read-side counterpart to the writeback path that fills the register file.
- It drives one of the file's asynchronous read-address ports and captures the returned data into an output register.
- It sits beside the register file and feeds a debug or trace sink.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE
- first_reg  input  ADDR_W  first register of the range; sampled with start
- last_reg  input  ADDR_W  last register of the range, inclusive; sampled with start
- abort  input  1  cancel the dump in progress
- rd_addr  output  ADDR_W  read address to the register file read port
- rd_data  input  DATA_W  combinational read data from the register file, valid in the same cycle as rd_addr
- out_valid  output  1  output beat valid
- out_ready  input  1  sink accepts the beat
- out_data  output  DATA_W  register contents
- out_addr  output  ADDR_W  register index of out_data
- out_last  output  1  beat is the last of the range
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse after the last beat is accepted
- err  output  1  one-cycle pulse when start is rejected

Behaviour:
- Reset (async, rst_n=0): state=IDLE. Outputs: out_valid=0, out_data=0, out_addr=0, out_last=0, busy=0, done=0, err=0. Internal: ptr=0, last_q=0, so rd_addr=0.
- rd_addr is always driven from the registered pointer ptr. There is no combinational path from any input to rd_addr.
- Beat fire: out_valid & out_ready on the same rising edge.
- IDLE:
  - start=1 and first_reg<=last_reg: ptr<=first_reg, last_q<=last_reg, go to LOAD.
  - start=1 and first_reg>last_reg: err=1 for one cycle, stay in IDLE.
- LOAD (exactly one cycle):
  - out_data<=rd_data, out_addr<=ptr, out_last<=(ptr==last_q), out_valid<=1, ptr<=ptr+1, go to SEND.
  - Latency from start to first out_valid is 2 cycles.
- SEND:
  - out_data, out_addr and out_last hold stable while out_valid=1 and out_ready=0.
  - On fire with out_last=0: out_data<=rd_data, out_addr<=ptr, out_last<=(ptr==last_q), ptr<=ptr+1. out_valid stays 1.
  - Sustained throughput is one beat per cycle.
  - On fire with out_last=1: out_valid<=0, out_last<=0, done=1 for one cycle, go to IDLE.
- ptr increments modulo 2^ADDR_W. It wraps 31->0 only after the final beat, and that value is never emitted.
- Single-register range (first_reg==last_reg): exactly one beat with out_last=1.
- Snapshot semantics:
  - Each register is sampled on the edge where its beat is loaded.
  - A write to register k that lands before that edge is visible in beat k. A write that lands after it is not.
  - The dump is not atomic across registers.
- abort=1 in LOAD or SEND:
  - Next cycle: out_valid=0, out_last=0, state=IDLE, no done pulse.
  - abort takes priority over a simultaneous fire; that beat counts as accepted by the sink but does not complete the dump.
- abort in IDLE: ignored.
- start while busy=1: ignored, no err.
- start and abort in the same IDLE cycle: start wins.
- Reset asserted mid-dump: immediate return to reset values. No done pulse.
- out_valid must never drop without a fire, abort or reset.

Test Plan:
- RF preloaded with R[i]=0xA5A50000+i; start with first=0, last=31, out_ready held 1 -> 32 consecutive beats, out_addr 0..31, out_data matches, out_last only on addr 31, done pulses one cycle after that beat, first out_valid 2 cycles after start.
- first=5, last=8; out_ready toggles 1,0,0,1,… -> beats 5,6,7,8 each held stable through stalls; out_last on 8; busy drops with done.
- first=last=17 -> single beat with out_addr=17 and out_last=1, then done. first=9, last=3 -> err pulse, busy stays 0, no beats.
- Dump 0..31 with writeback writing R10=0xDEADBEEF two cycles before beat 10 loads, then R2=0x12345678 after beat 2 has loaded -> beat 10 shows 0xDEADBEEF, beat 2 shows its old value.
- abort asserted at beat 4 of range 0..31 -> out_valid=0 next cycle, no done; a new start 0..1 then completes normally. Second start issued mid-dump -> ignored.
- rst_n pulsed low mid-dump (asynchronous, between edges) -> all outputs 0 immediately, state IDLE, no done.
